// File: rtl/mcs4_bus_monitor.sv
// -----------------------------------------------------------------------------
// mcs4_bus_monitor
//
// Passive observer for an MCS-4 style multiplexed 4-bit bus. Tracks the
// eight-phase instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3) from the two-phase
// bus clocks and SYNC, and reports completed instruction fetches, SRC
// chip/register selections and I/O-RAM instruction cycles. Never drives the bus.
//
// Parameters
//   CMRAM_MASK   bit n enables SRC/I-O decode qualified by cmram<n>_pad
//
// Ports
//   sysclk                 system clock, all state updates on its rising edge
//   poc_pad                synchronous active-high reset
//   clk1_pad, clk2_pad     two-phase bus clocks (synchronous to sysclk)
//   sync_pad               marks the X3 phase of every instruction cycle
//   cmrom_pad              ROM command line
//   cmram0_pad..cmram3_pad RAM bank command lines
//   data_pad[3:0]          bus data
//   fetch_valid/addr/opr/opa          completed instruction fetch
//   src_valid/bank/data               SRC selection observed
//   io_valid/rom/bank/opa/data        I/O-RAM instruction cycle observed
//   locked                 phase tracker aligned to SYNC
//   sync_err               one-sysclk pulse on SYNC misalignment
// -----------------------------------------------------------------------------
module mcs4_bus_monitor #(
   parameter logic [3:0] CMRAM_MASK = 4'b1111
) (
   input  logic        sysclk,
   input  logic        poc_pad,
   input  logic        clk1_pad,
   input  logic        clk2_pad,
   input  logic        sync_pad,
   input  logic        cmrom_pad,
   input  logic        cmram0_pad,
   input  logic        cmram1_pad,
   input  logic        cmram2_pad,
   input  logic        cmram3_pad,
   input  logic [3:0]  data_pad,
   output logic        fetch_valid,
   output logic [11:0] fetch_addr,
   output logic [3:0]  fetch_opr,
   output logic [3:0]  fetch_opa,
   output logic        src_valid,
   output logic [3:0]  src_bank,
   output logic [7:0]  src_data,
   output logic        io_valid,
   output logic        io_rom,
   output logic [3:0]  io_bank,
   output logic [3:0]  io_opa,
   output logic [3:0]  io_data,
   output logic        locked,
   output logic        sync_err
);

   // State names the phase whose end is expected next.
   typedef enum logic [3:0] {
      UNSYNC, A1, A2, A3, M1, M2, X1, X2, X3
   } phase_t;

   phase_t      state;
   logic        clk2_q;
   logic        phase_end;
   logic [3:0]  cmram_vec;

   // Working registers for the cycle in progress.
   logic [11:0] addr_w;
   logic [3:0]  opr_w;
   logic [3:0]  opa_w;
   logic        io_rom_w;
   logic [3:0]  io_bank_w;
   logic [3:0]  src_hi_w;
   logic [3:0]  src_bank_w;
   logic        src_arm;
   logic        io_arm;
   logic        second_word;

   // clk1 is not needed: phase boundaries are taken from clk2 alone.
   logic        unused_clk1;
   assign unused_clk1 = clk1_pad;

   assign phase_end = clk2_q & ~clk2_pad;
   assign cmram_vec = {cmram3_pad, cmram2_pad, cmram1_pad, cmram0_pad} & CMRAM_MASK;

   // First word of a two-word instruction: FIM (2, even opa), JCN, JUN, JMS, ISZ.
   function automatic logic is_two_word(input logic [3:0] opr, input logic [3:0] opa);
      logic r;
      r = 1'b0;
      case (opr)
         4'h1, 4'h4, 4'h5, 4'h7: r = 1'b1;
         4'h2:                   r = ~opa[0];
         default:                r = 1'b0;
      endcase
      return r;
   endfunction

   always_ff @(posedge sysclk) begin
      if (poc_pad) begin
         state       <= UNSYNC;
         clk2_q      <= 1'b0;
         locked      <= 1'b0;
         sync_err    <= 1'b0;
         fetch_valid <= 1'b0;
         fetch_addr  <= '0;
         fetch_opr   <= '0;
         fetch_opa   <= '0;
         src_valid   <= 1'b0;
         src_bank    <= '0;
         src_data    <= '0;
         io_valid    <= 1'b0;
         io_rom      <= 1'b0;
         io_bank     <= '0;
         io_opa      <= '0;
         io_data     <= '0;
         addr_w      <= '0;
         opr_w       <= '0;
         opa_w       <= '0;
         io_rom_w    <= 1'b0;
         io_bank_w   <= '0;
         src_hi_w    <= '0;
         src_bank_w  <= '0;
         src_arm     <= 1'b0;
         io_arm      <= 1'b0;
         second_word <= 1'b0;
      end else begin
         clk2_q      <= clk2_pad;
         fetch_valid <= 1'b0;
         src_valid   <= 1'b0;
         io_valid    <= 1'b0;
         sync_err    <= 1'b0;

         if (phase_end) begin
            if (state == UNSYNC) begin
               if (sync_pad) begin
                  state  <= A1;
                  locked <= 1'b1;
               end
            end else if ((state == X3) && !sync_pad) begin
               // SYNC missing where expected: alignment lost entirely.
               sync_err    <= 1'b1;
               locked      <= 1'b0;
               state       <= UNSYNC;
               src_arm     <= 1'b0;
               io_arm      <= 1'b0;
               second_word <= 1'b0;
            end else if ((state != X3) && sync_pad) begin
               // Early SYNC: drop the partial cycle and realign on it.
               sync_err    <= 1'b1;
               state       <= A1;
               src_arm     <= 1'b0;
               io_arm      <= 1'b0;
               second_word <= 1'b0;
            end else begin
               case (state)
                  A1: begin
                     addr_w[3:0] <= data_pad;
                     state       <= A2;
                  end
                  A2: begin
                     addr_w[7:4] <= data_pad;
                     state       <= A3;
                  end
                  A3: begin
                     addr_w[11:8] <= data_pad;
                     state        <= M1;
                  end
                  M1: begin
                     opr_w <= data_pad;
                     state <= M2;
                  end
                  M2: begin
                     fetch_valid <= 1'b1;
                     fetch_addr  <= addr_w;
                     fetch_opr   <= opr_w;
                     fetch_opa   <= data_pad;
                     opa_w       <= data_pad;
                     io_rom_w    <= cmrom_pad;
                     io_bank_w   <= cmram_vec;
                     // The second word of a two-word instruction is data,
                     // so it must neither arm decode nor start another pair.
                     if (second_word) begin
                        second_word <= 1'b0;
                        src_arm     <= 1'b0;
                        io_arm      <= 1'b0;
                     end else begin
                        second_word <= is_two_word(opr_w, data_pad);
                        src_arm     <= (opr_w == 4'h2) && data_pad[0];
                        io_arm      <= (opr_w == 4'hE);
                     end
                     state <= X1;
                  end
                  X1: begin
                     state <= X2;
                  end
                  X2: begin
                     src_hi_w   <= data_pad;
                     src_bank_w <= cmram_vec;
                     if (io_arm && (io_rom_w || (io_bank_w != 4'h0))) begin
                        io_valid <= 1'b1;
                        io_rom   <= io_rom_w;
                        io_bank  <= io_bank_w;
                        io_opa   <= opa_w;
                        io_data  <= data_pad;
                     end
                     io_arm <= 1'b0;
                     state  <= X3;
                  end
                  X3: begin
                     if (src_arm && (src_bank_w != 4'h0)) begin
                        src_valid <= 1'b1;
                        src_bank  <= src_bank_w;
                        src_data  <= {src_hi_w, data_pad};
                     end
                     src_arm <= 1'b0;
                     state   <= A1;
                  end
                  default: begin
                     state <= UNSYNC;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_mcs4_bus_monitor.sv
// -----------------------------------------------------------------------------
// tb_mcs4_bus_monitor
//
// Two monitors (CMRAM_MASK 4'b1111 and 4'b1011) watch the same bus. Stimulus
// drives bus phases and feeds a cycle-level reference model that queues the
// expected reports; an independent monitor pops and compares each pulse.
// -----------------------------------------------------------------------------
module tb_mcs4_bus_monitor;

   localparam int K_FETCH = 0;
   localparam int K_SRC   = 1;
   localparam int K_IO    = 2;
   localparam int K_ERR   = 3;

   logic        sysclk    = 1'b0;
   logic        poc_pad   = 1'b1;
   logic        clk1_pad  = 1'b0;
   logic        clk2_pad  = 1'b0;
   logic        sync_pad  = 1'b0;
   logic        cmrom_pad = 1'b0;
   logic [3:0]  cmram     = 4'h0;
   logic [3:0]  data_pad  = 4'h0;

   logic [1:0]       fetch_valid, src_valid, io_valid, io_rom, locked, sync_err;
   logic [1:0][11:0] fetch_addr;
   logic [1:0][3:0]  fetch_opr, fetch_opa, src_bank, io_bank, io_opa, io_data;
   logic [1:0][7:0]  src_data;

   always #5 sysclk = ~sysclk;

   mcs4_bus_monitor #(.CMRAM_MASK(4'b1111)) u_dut0 (
      .sysclk(sysclk), .poc_pad(poc_pad), .clk1_pad(clk1_pad), .clk2_pad(clk2_pad),
      .sync_pad(sync_pad), .cmrom_pad(cmrom_pad),
      .cmram0_pad(cmram[0]), .cmram1_pad(cmram[1]), .cmram2_pad(cmram[2]), .cmram3_pad(cmram[3]),
      .data_pad(data_pad),
      .fetch_valid(fetch_valid[0]), .fetch_addr(fetch_addr[0]), .fetch_opr(fetch_opr[0]),
      .fetch_opa(fetch_opa[0]), .src_valid(src_valid[0]), .src_bank(src_bank[0]),
      .src_data(src_data[0]), .io_valid(io_valid[0]), .io_rom(io_rom[0]), .io_bank(io_bank[0]),
      .io_opa(io_opa[0]), .io_data(io_data[0]), .locked(locked[0]), .sync_err(sync_err[0])
   );

   mcs4_bus_monitor #(.CMRAM_MASK(4'b1011)) u_dut1 (
      .sysclk(sysclk), .poc_pad(poc_pad), .clk1_pad(clk1_pad), .clk2_pad(clk2_pad),
      .sync_pad(sync_pad), .cmrom_pad(cmrom_pad),
      .cmram0_pad(cmram[0]), .cmram1_pad(cmram[1]), .cmram2_pad(cmram[2]), .cmram3_pad(cmram[3]),
      .data_pad(data_pad),
      .fetch_valid(fetch_valid[1]), .fetch_addr(fetch_addr[1]), .fetch_opr(fetch_opr[1]),
      .fetch_opa(fetch_opa[1]), .src_valid(src_valid[1]), .src_bank(src_bank[1]),
      .src_data(src_data[1]), .io_valid(io_valid[1]), .io_rom(io_rom[1]), .io_bank(io_bank[1]),
      .io_opa(io_opa[1]), .io_data(io_data[1]), .locked(locked[1]), .sync_err(sync_err[1])
   );

   // ---------------- scoreboard ----------------
   typedef struct {
      int          kind;
      int          inst;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passes = 0;

   function automatic void push(input int kind, input int k, input int v);
      exp_t e;
      e.kind = kind;
      e.inst = k;
      e.val  = 32'(v);
      exp_q.push_back(e);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %h required %h", name, act, req);
   endtask

   task automatic sb_check(input string name, input int kind, input int k, input logic [31:0] act);
      int idx;
      idx = -1;
      foreach (exp_q[i])
         if (idx < 0 && exp_q[i].kind == kind && exp_q[i].inst == k) idx = i;
      checks++;
      if (idx < 0) begin
         $display("FAIL %s[%0d]: unexpected pulse with value %h, no pulse required", name, k, act);
      end else begin
         if (act === exp_q[idx].val) passes++;
         else $display("FAIL %s[%0d]: got %h required %h", name, k, act, exp_q[idx].val);
         exp_q.delete(idx);
      end
   endtask

   always @(negedge sysclk) begin
      for (int k = 0; k < 2; k++) begin
         if (fetch_valid[k])
            sb_check("fetch", K_FETCH, k, {12'h0, fetch_addr[k], fetch_opr[k], fetch_opa[k]});
         if (src_valid[k])
            sb_check("src", K_SRC, k, {20'h0, src_bank[k], src_data[k]});
         if (io_valid[k])
            sb_check("io", K_IO, k, {19'h0, io_rom[k], io_bank[k], io_opa[k], io_data[k]});
         if (sync_err[k])
            sb_check("sync_err", K_ERR, k, {31'h0, locked[k]});
      end
   end

   // ---------------- reference model ----------------
   // Collects the nibbles of the current instruction cycle by position and
   // derives each report when the phase that completes it ends.
   logic [3:0] mask [2] = '{4'hF, 4'hB};
   bit         m_locked = 1'b0;
   bit         m_sw     = 1'b0;   // next fetch is the second word of a pair
   bit         m_dec    = 1'b0;   // current fetch may decode SRC / I-O
   int         m_pos    = 0;      // 0..7 = A1..X3 expected next
   logic [3:0] nib    [8];
   logic [3:0] ram_at [8];
   bit         rom_at [8];

   function automatic bit two_word(input logic [3:0] opr, input logic [3:0] opa);
      return (opr == 4'h1) || (opr == 4'h4) || (opr == 4'h5) || (opr == 4'h7) ||
             (opr == 4'h2 && opa[0] == 1'b0);
   endfunction

   function automatic void model_reset();
      m_locked = 1'b0;
      m_sw     = 1'b0;
      m_dec    = 1'b0;
      m_pos    = 0;
   endfunction

   function automatic void model_phase(input bit s, input logic [3:0] d, input bit rom,
                                       input logic [3:0] ram);
      int a;
      logic [3:0] bank;
      if (!m_locked) begin
         if (s) begin
            m_locked = 1'b1;
            m_pos    = 0;
         end
         return;
      end
      if ((m_pos == 7) != s) begin
         m_sw = 1'b0;
         if (m_pos == 7) m_locked = 1'b0;
         else m_pos = 0;
         for (int k = 0; k < 2; k++) push(K_ERR, k, int'(m_locked));
         return;
      end
      nib[m_pos]    = d;
      rom_at[m_pos] = rom;
      ram_at[m_pos] = ram;
      if (m_pos == 4) begin
         a = 256 * int'(nib[2]) + 16 * int'(nib[1]) + int'(nib[0]);
         for (int k = 0; k < 2; k++) push(K_FETCH, k, (a * 16 + int'(nib[3])) * 16 + int'(d));
         if (m_sw) begin
            m_sw  = 1'b0;
            m_dec = 1'b0;
         end else begin
            m_dec = 1'b1;
            m_sw  = two_word(nib[3], d);
         end
      end
      if (m_pos == 6 && m_dec && nib[3] == 4'hE) begin
         for (int k = 0; k < 2; k++) begin
            bank = ram_at[4] & mask[k];
            if (rom_at[4] || bank != 4'h0)
               push(K_IO, k, int'(rom_at[4]) * 4096 + int'(bank) * 256 + int'(nib[4]) * 16 + int'(d));
         end
      end
      if (m_pos == 7 && m_dec && nib[3] == 4'h2 && nib[4][0]) begin
         for (int k = 0; k < 2; k++) begin
            bank = ram_at[6] & mask[k];
            if (bank != 4'h0) push(K_SRC, k, int'(bank) * 256 + int'(nib[6]) * 16 + int'(d));
         end
      end
      m_pos = (m_pos + 1) % 8;
   endfunction

   // ---------------- stimulus helpers ----------------
   // One bus phase: clk1 pulse, clk2 pulse, then clk2 falls with inputs held.
   task automatic phase(input bit s, input logic [3:0] d, input bit rom, input logic [3:0] ram,
                        input bit por = 1'b0);
      @(negedge sysclk);
      sync_pad = s; data_pad = d; cmrom_pad = rom; cmram = ram; clk1_pad = 1'b1;
      @(negedge sysclk);
      clk1_pad = 1'b0; clk2_pad = 1'b1;
      @(negedge sysclk);
      @(negedge sysclk);
      clk2_pad = 1'b0;
      if (por) begin
         poc_pad = 1'b1;
         model_reset();
      end else begin
         model_phase(s, d, rom, ram);
      end
      @(negedge sysclk);
      poc_pad = 1'b0;
      @(negedge sysclk);
      for (int k = 0; k < 2; k++) chk($sformatf("locked[%0d]", k), {31'h0, locked[k]}, {31'h0, m_locked});
   endtask

   task automatic cycle(input logic [11:0] a, input logic [3:0] opr, input logic [3:0] opa,
                        input bit rom4, input logic [3:0] ram4, input logic [3:0] ram6,
                        input logic [3:0] x2d, input logic [3:0] x3d);
      phase(1'b0, a[3:0], 1'b0, 4'h0);
      phase(1'b0, a[7:4], 1'b0, 4'h0);
      phase(1'b0, a[11:8], 1'b0, 4'h0);
      phase(1'b0, opr, 1'b0, 4'h0);
      phase(1'b0, opa, rom4, ram4);
      phase(1'b0, 4'($urandom_range(0, 15)), 1'b0, 4'h0);
      phase(1'b0, x2d, 1'b0, ram6);
      phase(1'b1, x3d, 1'b0, 4'h0);
   endtask

   task automatic drain(input string name);
      repeat (3) @(negedge sysclk);
      chk({name, " pending"}, 32'(exp_q.size()), 32'h0);
      exp_q.delete();
   endtask

   task automatic check_zero(input string name);
      chk(name, {31'h0, |{fetch_valid, src_valid, io_valid, io_rom, locked, sync_err,
                          fetch_addr, fetch_opr, fetch_opa, src_bank, src_data,
                          io_bank, io_opa, io_data}}, 32'h0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [11:0] pc;
      logic [3:0]  rn [8];
      bit          s;

      repeat (4) @(negedge sysclk);
      poc_pad = 1'b0;
      model_reset();
      @(negedge sysclk);
      check_zero("reset outputs");

      // Lock on SYNC, then a plain fetch at 0x024.
      phase(1'b1, 4'h0, 1'b0, 4'h0);
      cycle(12'h024, 4'hD, 4'h5, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      chk("fetch_addr", {20'h0, fetch_addr[0]}, 32'h024);
      chk("fetch_opr/opa", {24'h0, fetch_opr[0], fetch_opa[0]}, 32'hD5);
      drain("basic fetch");

      // SRC via cmram0.
      cycle(12'h025, 4'h2, 4'h1, 1'b0, 4'h0, 4'b0001, 4'hA, 4'h3);
      chk("src_data", {24'h0, src_data[0]}, 32'hA3);
      chk("src_bank", {28'h0, src_bank[0]}, 32'h1);
      drain("src");

      // I/O instruction with cmram2; masked out on instance 1.
      cycle(12'h026, 4'hE, 4'h0, 1'b0, 4'b0100, 4'h0, 4'h7, 4'h0);
      chk("io fields", {19'h0, io_rom[0], io_bank[0], io_opa[0], io_data[0]}, 32'h0407);
      drain("io");

      // SYNC missing at X3, then nothing until resync.
      cycle(12'h027, 4'hD, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      for (int p = 0; p < 8; p++) phase(1'b0, 4'(p + 3), 1'b0, 4'h0);
      for (int p = 0; p < 8; p++) phase(1'b0, 4'(p), 1'b0, 4'h0);
      phase(1'b1, 4'h0, 1'b0, 4'h0);
      cycle(12'h100, 4'hD, 4'h1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      drain("sync loss");

      // Early SYNC at M1: partial cycle dropped, next phase is A1.
      phase(1'b0, 4'h1, 1'b0, 4'h0);
      phase(1'b0, 4'h2, 1'b0, 4'h0);
      phase(1'b0, 4'h3, 1'b0, 4'h0);
      phase(1'b1, 4'h2, 1'b0, 4'h0);
      cycle(12'h3C5, 4'hD, 4'h2, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      chk("fetch after realign", {20'h0, fetch_addr[0]}, 32'h3C5);
      drain("early sync");

      // Reset coinciding with the X2 phase end of an armed SRC.
      for (int p = 0; p < 6; p++) phase(1'b0, (p == 3) ? 4'h2 : (p == 4) ? 4'h1 : 4'h0, 1'b0, 4'h0);
      phase(1'b0, 4'hA, 1'b0, 4'b0001, 1'b1);
      check_zero("outputs after mid-cycle reset");
      for (int p = 0; p < 3; p++) phase(1'b0, 4'(p + 9), 1'b1, 4'hF);
      check_zero("outputs before resync");
      phase(1'b1, 4'h3, 1'b0, 4'h0);
      drain("mid-cycle reset");

      // JUN followed by a second word that looks like SRC.
      cycle(12'h200, 4'h4, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      cycle(12'h201, 4'h2, 4'h1, 1'b0, 4'h0, 4'b0001, 4'hA, 4'h3);
      drain("two-word");

      // Random cycles across the 12-bit wrap with occasional SYNC faults.
      pc = 12'hFF0;
      for (int c = 0; c < 150; c++) begin
         case ($urandom_range(0, 5))
            0:       rn[3] = 4'h2;
            1:       rn[3] = 4'hE;
            2:       rn[3] = 4'h4;
            default: rn[3] = 4'($urandom_range(0, 15));
         endcase
         rn[0] = pc[3:0];
         rn[1] = pc[7:4];
         rn[2] = pc[11:8];
         for (int p = 4; p < 8; p++) rn[p] = 4'($urandom_range(0, 15));
         for (int p = 0; p < 8; p++) begin
            s = (p == 7);
            if ($urandom_range(0, 59) == 0) s = ~s;
            phase(s, rn[p], 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         end
         pc = pc + 12'h001;
      end
      drain("random");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
